// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a framed program image byte-by-byte from a serial receiver and
// writes it into the CPU's program memory, then pulses the CPU reset.
//
// Frame: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x {hi, lo}, CSUM
// The 8-bit sum of every byte after SYNC (CSUM included) must be zero.
//
// Ports
//   clk       in   system clock (also the CPU's pclk)
//   rst       in   synchronous active-high reset
//   rx_data   in   [7:0] received byte
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   pgm       out  program-mode request to the CPU
//   pgm_addr  out  [15:0] program write address
//   pgm_data  out  [15:0] program write word
//   pg_wr     out  one-cycle program-memory write strobe
//   cpu_rst   out  CPU reset pulse after a good frame
//   busy      out  high while a frame is in progress (state != IDLE)
//   done      out  sticky: last frame loaded successfully
//   err       out  [1:0] sticky error: 00 none, 01 checksum, 10 timeout
// -----------------------------------------------------------------------------
module prog_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          CPU_RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        pgm,
  output logic [15:0] pgm_addr,
  output logic [15:0] pgm_data,
  output logic        pg_wr,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, CNT_H, CNT_L, DATA_H, DATA_L, CSUM, FINISH
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] addr_reg, addr_next;          // current write address
  logic [15:0] cnt_reg, cnt_next;            // remaining word count
  logic [7:0]  hi_reg, hi_next;              // latched hi byte of a word
  logic [7:0]  sum_reg, sum_next;            // running checksum
  logic [23:0] tcnt_reg, tcnt_next;          // inter-byte timeout counter
  logic [3:0]  rcnt_reg, rcnt_next;          // cpu_rst cycles still to go
  logic        pgm_reg, pgm_next;
  logic [15:0] pgm_addr_reg, pgm_addr_next;
  logic [15:0] pgm_data_reg, pgm_data_next;
  logic        pg_wr_reg, pg_wr_next;
  logic        cpu_rst_reg, cpu_rst_next;
  logic        done_reg, done_next;
  logic [1:0]  err_reg, err_next;

  logic        in_frame;
  logic [7:0]  sum_with_rx;
  logic [15:0] cnt_full;

  // Timed states: everything between SYNC and the checksum byte.
  assign in_frame    = (state_reg != IDLE) && (state_reg != FINISH);
  assign sum_with_rx = sum_reg + rx_data;
  assign cnt_full    = {cnt_reg[15:8], rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      hi_reg       <= '0;
      sum_reg      <= '0;
      tcnt_reg     <= '0;
      rcnt_reg     <= '0;
      pgm_reg      <= 1'b0;
      pgm_addr_reg <= '0;
      pgm_data_reg <= '0;
      pg_wr_reg    <= 1'b0;
      cpu_rst_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 2'b00;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      hi_reg       <= hi_next;
      sum_reg      <= sum_next;
      tcnt_reg     <= tcnt_next;
      rcnt_reg     <= rcnt_next;
      pgm_reg      <= pgm_next;
      pgm_addr_reg <= pgm_addr_next;
      pgm_data_reg <= pgm_data_next;
      pg_wr_reg    <= pg_wr_next;
      cpu_rst_reg  <= cpu_rst_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    hi_next       = hi_reg;
    sum_next      = sum_reg;
    tcnt_next     = '0;
    rcnt_next     = rcnt_reg;
    pgm_next      = pgm_reg;
    pgm_addr_next = pgm_addr_reg;
    pgm_data_next = pgm_data_reg;
    pg_wr_next    = 1'b0;
    cpu_rst_next  = cpu_rst_reg;
    done_next     = done_reg;
    err_next      = err_reg;

    if (in_frame) begin
      tcnt_next = rx_valid ? 24'd0 : tcnt_reg + 24'd1;
      if (rx_valid) sum_next = sum_with_rx;
    end

    case (state_reg)
      IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_next = ADDR_H;
          pgm_next   = 1'b1;
          done_next  = 1'b0;
          err_next   = 2'b00;
          sum_next   = 8'h00;
        end
      end
      ADDR_H: if (rx_valid) begin
        addr_next  = {rx_data, addr_reg[7:0]};
        state_next = ADDR_L;
      end
      ADDR_L: if (rx_valid) begin
        addr_next  = {addr_reg[15:8], rx_data};
        state_next = CNT_H;
      end
      CNT_H: if (rx_valid) begin
        cnt_next   = {rx_data, cnt_reg[7:0]};
        state_next = CNT_L;
      end
      CNT_L: if (rx_valid) begin
        cnt_next   = cnt_full;
        // An empty image skips straight to the checksum byte.
        state_next = (cnt_full == 16'd0) ? CSUM : DATA_H;
      end
      DATA_H: if (rx_valid) begin
        hi_next    = rx_data;
        state_next = DATA_L;
      end
      DATA_L: if (rx_valid) begin
        pgm_addr_next = addr_reg;
        pgm_data_next = {hi_reg, rx_data};
        pg_wr_next    = 1'b1;
        addr_next     = addr_reg + 16'd1;
        cnt_next      = cnt_reg - 16'd1;
        state_next    = (cnt_reg == 16'd1) ? CSUM : DATA_H;
      end
      CSUM: if (rx_valid) begin
        pgm_next = 1'b0;
        if (sum_with_rx == 8'h00) begin
          state_next   = FINISH;
          done_next    = 1'b1;
          cpu_rst_next = 1'b1;
          rcnt_next    = 4'(CPU_RST_CYCLES - 1);
        end else begin
          state_next = IDLE;
          err_next   = 2'b01;
        end
      end
      FINISH: begin
        // Incoming bytes are dropped here; only the reset pulse is timed.
        if (rcnt_reg == 4'd0) begin
          cpu_rst_next = 1'b0;
          state_next   = IDLE;
        end else begin
          rcnt_next = rcnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Silence on the line for too long abandons the frame; earlier writes stand.
    if (in_frame && !rx_valid && tcnt_reg == 24'(TIMEOUT_CYCLES - 1)) begin
      state_next = IDLE;
      pgm_next   = 1'b0;
      err_next   = 2'b10;
    end
  end

  assign pgm      = pgm_reg;
  assign pgm_addr = pgm_addr_reg;
  assign pgm_data = pgm_data_reg;
  assign pg_wr    = pg_wr_reg;
  assign cpu_rst  = cpu_rst_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. A frame builder computes the expected
// program writes and checksum from the frame rules; a negedge monitor logs
// what the DUT actually does (writes, cpu_rst cycles, pgm falling edges).
// -----------------------------------------------------------------------------
module tb_prog_loader;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pgm;
  logic [15:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        pg_wr;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  always #5 clk = ~clk;

  prog_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO),
    .CPU_RST_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .pgm(pgm), .pgm_addr(pgm_addr), .pgm_data(pgm_data), .pg_wr(pg_wr),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- monitor (sole writer of these) ----------------
  logic [31:0] got_q[$];
  int          rst_cycles = 0;
  int          fall_count = 0;
  logic        rst_at_fall = 1'b0;
  logic        pgm_prev = 1'b0;

  always @(negedge clk) begin
    if (pg_wr) got_q.push_back({pgm_addr, pgm_data});
    if (cpu_rst) rst_cycles++;
    if (pgm_prev && !pgm) begin
      fall_count++;
      rst_at_fall = cpu_rst;
    end
    pgm_prev = pgm;
  end

  // ---------------- stimulus / reference model ----------------
  logic [15:0] words[16];
  logic [31:0] exp_q[$];

  // Called at posedge+1; returns at the next posedge+1.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Builds a frame, records the writes it must produce, and sends it.
  // delta == 0 gives a correct checksum; any other value corrupts it.
  task automatic send_frame(input logic [15:0] a, input int n,
                            input logic [7:0] delta, input int maxgap);
    logic [7:0] body[$];
    logic [7:0] s;
    logic [7:0] cs;
    logic [15:0] n16;
    n16  = 16'(n);
    body = {};
    body.push_back(a[15:8]);
    body.push_back(a[7:0]);
    body.push_back(n16[15:8]);
    body.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      body.push_back(words[i][15:8]);
      body.push_back(words[i][7:0]);
      exp_q.push_back({a + 16'(i), words[i]});
    end
    s = 8'h00;
    foreach (body[i]) s = s + body[i];
    cs = 8'h00 - s;
    cs = cs + delta;
    body.push_back(cs);
    send_byte(8'hA5);
    foreach (body[i]) begin
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      send_byte(body[i]);
    end
  endtask

  // Bounded wait for the FSM to return to IDLE; ends at posedge+1.
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({pgm, pg_wr, cpu_rst, busy, done, err, pgm_addr, pgm_data} !== 39'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got pgm=%b wr=%b crst=%b busy=%b done=%b err=%b addr=%h data=%h, need all 0",
               pgm, pg_wr, cpu_rst, busy, done, err, pgm_addr, pgm_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_good_frame;
    int base, rb, fb; bit ok;
    base = got_q.size(); rb = rst_cycles; fb = fall_count; exp_q = {};
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(16'h000F, 2, 8'h00, 0);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL good_idle: busy stuck high"); end
    vectors++;
    if (got_q.size() - base != 2) begin
      miscompares++; $display("FAIL good_wr_count: got %0d need 2", got_q.size() - base);
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_q[base+i] !== exp_q[i]) begin
          miscompares++; $display("FAIL good_wr%0d: got %h need %h", i, got_q[base+i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (done !== 1'b1 || err !== 2'b00) begin
      miscompares++; $display("FAIL good_status: got done=%b err=%b need 1/00", done, err);
    end
    vectors++;
    if (rst_cycles - rb != 4) begin
      miscompares++; $display("FAIL good_cpu_rst_len: got %0d need 4", rst_cycles - rb);
    end
    vectors++;
    if (fall_count - fb != 1 || rst_at_fall !== 1'b1) begin
      miscompares++; $display("FAIL good_pgm_fall: falls=%0d crst_at_fall=%b need 1/1", fall_count - fb, rst_at_fall);
    end
    $display("test_good_frame: writes=%0d done=%b err=%b", got_q.size() - base, done, err);
  endtask

  task automatic test_bad_csum;
    int base, rb, fb; bit ok;
    base = got_q.size(); rb = rst_cycles; fb = fall_count; exp_q = {};
    words[0] = 16'h1234; words[1] = 16'hABCD;
    send_frame(16'h000F, 2, 8'h01, 0);
    wait_idle(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bad_idle: busy stuck high"); end
    vectors++;
    if (got_q.size() - base != 2) begin
      miscompares++; $display("FAIL bad_wr_count: got %0d need 2", got_q.size() - base);
    end else if (got_q[base+1] !== exp_q[1]) begin
      miscompares++; $display("FAIL bad_wr1: got %h need %h", got_q[base+1], exp_q[1]);
    end
    vectors++;
    if (done !== 1'b0 || err !== 2'b01 || pgm !== 1'b0) begin
      miscompares++; $display("FAIL bad_status: got done=%b err=%b pgm=%b need 0/01/0", done, err, pgm);
    end
    vectors++;
    if (rst_cycles - rb != 0 || fall_count - fb != 1) begin
      miscompares++; $display("FAIL bad_cpu_rst: got %0d rst cycles, %0d falls, need 0/1", rst_cycles - rb, fall_count - fb);
    end
    $display("test_bad_csum: done=%b err=%b", done, err);
  endtask

  task automatic test_wrap;
    int base; bit ok;
    base = got_q.size(); exp_q = {};
    words[0] = 16'($urandom); words[1] = 16'($urandom);
    send_frame(16'hFFFF, 2, 8'h00, 1);
    wait_idle(ok);
    vectors++;
    if (got_q.size() - base != 2) begin
      miscompares++; $display("FAIL wrap_count: got %0d need 2", got_q.size() - base);
    end else begin
      vectors++;
      if (got_q[base+1] !== exp_q[1] || got_q[base+1][31:16] !== 16'h0000) begin
        miscompares++; $display("FAIL wrap_addr: got %h need %h", got_q[base+1], exp_q[1]);
      end
    end
    $display("test_wrap: ok=%b", ok);
  endtask

  task automatic test_zero_count;
    int base, rb; bit ok;
    base = got_q.size(); rb = rst_cycles; exp_q = {};
    send_frame(16'h0010, 0, 8'h00, 0);   // checksum byte works out to F0
    wait_idle(ok);
    vectors++;
    if (got_q.size() != base || done !== 1'b1 || err !== 2'b00 || rst_cycles - rb != 4) begin
      miscompares++;
      $display("FAIL zero_count: writes=%0d done=%b err=%b rstcyc=%0d need 0/1/00/4",
               got_q.size() - base, done, err, rst_cycles - rb);
    end
    $display("test_zero_count: done=%b", done);
  endtask

  task automatic test_timeout;
    int base;
    base = got_q.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h0F);
    idle(TO - 4);
    vectors++;
    if (busy !== 1'b1 || pgm !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early: got busy=%b pgm=%b need 1/1", busy, pgm);
    end
    idle(8);
    vectors++;
    if (err !== 2'b10 || pgm !== 1'b0 || busy !== 1'b0 || got_q.size() != base) begin
      miscompares++;
      $display("FAIL timeout: got err=%b pgm=%b busy=%b writes=%0d need 10/0/0/0", err, pgm, busy, got_q.size() - base);
    end
    $display("test_timeout: err=%b", err);
  endtask

  task automatic test_junk_and_reset;
    int base; bit ok;
    base = got_q.size(); exp_q = {};
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL junk_busy: got %b need 0", busy); end
    for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
    send_frame(16'h4000, 3, 8'h00, 2);
    wait_idle(ok);
    vectors++;
    if (got_q.size() - base != 3 || done !== 1'b1) begin
      miscompares++; $display("FAIL junk_frame: writes=%0d done=%b need 3/1", got_q.size() - base, done);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got_q[base+i] !== exp_q[i]) begin
          miscompares++; $display("FAIL junk_wr%0d: got %h need %h", i, got_q[base+i], exp_q[i]);
        end
      end
    end
    // Abort in DATA_H after one word has been written.
    base = got_q.size();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({pgm, pg_wr, cpu_rst, busy, done, err, pgm_addr, pgm_data} !== 39'd0) begin
      miscompares++;
      $display("FAIL midreset: got pgm=%b wr=%b crst=%b busy=%b done=%b err=%b addr=%h data=%h, need all 0",
               pgm, pg_wr, cpu_rst, busy, done, err, pgm_addr, pgm_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_byte(8'h33); send_byte(8'h44);
    idle(3);
    vectors++;
    if (got_q.size() - base != 1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_after: writes=%0d busy=%b need 1/0", got_q.size() - base, busy);
    end
    $display("test_junk_and_reset: writes before reset=%0d", got_q.size() - base);
  endtask

  task automatic test_back_to_back;
    int base; bit ok;
    base = got_q.size(); exp_q = {};
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    send_frame(16'h1230, 4, 8'h00, 0);
    // These land in FINISH and must be dropped, SYNC included.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    wait_idle(ok);
    vectors++;
    if (!ok || done !== 1'b1 || busy !== 1'b0 || got_q.size() - base != 4) begin
      miscompares++;
      $display("FAIL b2b_status: ok=%b done=%b busy=%b writes=%0d need 1/1/0/4", ok, done, busy, got_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got_q[base+i] !== exp_q[i]) begin
          miscompares++; $display("FAIL b2b_wr%0d: got %h need %h", i, got_q[base+i], exp_q[i]);
        end
      end
    end
    $display("test_back_to_back: writes=%0d", got_q.size() - base);
  endtask

  task automatic test_random;
    int base, rb, n; bit ok; logic [15:0] a; logic [7:0] delta; bit good;
    for (int f = 0; f < 8; f++) begin
      base = got_q.size(); rb = rst_cycles; exp_q = {};
      n    = $urandom_range(6, 0);
      a    = 16'($urandom);
      good = ($urandom_range(1, 0) == 1);
      delta = good ? 8'h00 : 8'($urandom_range(255, 1));
      for (int i = 0; i < n; i++) words[i] = 16'($urandom);
      send_frame(a, n, delta, 3);
      wait_idle(ok);
      vectors++;
      if (!ok || got_q.size() - base != n) begin
        miscompares++; $display("FAIL rand%0d_count: ok=%b writes=%0d need %0d", f, ok, got_q.size() - base, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          vectors++;
          if (got_q[base+i] !== exp_q[i]) begin
            miscompares++; $display("FAIL rand%0d_wr%0d: got %h need %h", f, i, got_q[base+i], exp_q[i]);
          end
        end
      end
      vectors++;
      if (done !== good || err !== (good ? 2'b00 : 2'b01) || rst_cycles - rb != (good ? 4 : 0)) begin
        miscompares++;
        $display("FAIL rand%0d_status: done=%b err=%b rstcyc=%0d need %b/%b/%0d",
                 f, done, err, rst_cycles - rb, good, good ? 2'b00 : 2'b01, good ? 4 : 0);
      end
      $display("test_random frame %0d: addr=%h n=%0d good=%b", f, a, n, good);
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_csum;
    test_wrap;
    test_zero_count;
    test_timeout;
    test_junk_and_reset;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
